irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Interrupt controller placed directly upstream of the monocycle control unit.
- Synchronises and edge-detects external interrupt lines, latches them as pending, and applies a per-line mask and fixed priority.
- Drives the control unit's s_interrup request for one cycle and supplies the vector address to the PC mux.
- Stays in service until the control unit's finInterrup (return-from-interrupt) arrives; no nesting.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..8).
- VEC_WIDTH, 10, PC/vector address width.
- VEC_BASE, 10'h3C0, vector address of line 0.
- VEC_STRIDE, 16, address distance between consecutive line vectors.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  external interrupt lines, asynchronous, level.
- mask_we  in  1  mask write strobe.
- mask_d  in  NUM_IRQ  new mask value (1 = enabled).
- fin_interrup  in  1  return-from-interrupt strobe, driven by the control unit's finInterrup.
- s_interrup  out  1  interrupt request to the control unit (PC push and vector load).
- vec_addr  out  VEC_WIDTH  vector of the accepted line.
- in_service  out  1  high from acceptance until fin_interrup.
- irq_id  out  3  index of the accepted line.
- pending  out  NUM_IRQ  pending register, for observation.
- mask  out  NUM_IRQ  mask register.

Behaviour:
- Reset (asynchronous, reset=0):
  - sync flops, edge-history flops, pending, mask, irq_id and vec_addr all clear to 0.
  - state = IDLE; s_interrup = 0; in_service = 0.
- Input conditioning:
  - Each irq_in bit passes through a 2-flop synchroniser, then a rising-edge detector (sync2 & ~prev).
  - Edge-to-pending latency: 3 clk edges after irq_in rises (sync1, sync2, pending set).
- Pending register:
  - A bit is set on its detected edge.
  - A bit is cleared when its line is accepted.
  - If set and clear hit the same bit in the same cycle, set wins, so a re-edge is never lost.
  - Masked lines still latch pending.
- Mask:
  - On mask_we, mask <= mask_d at the clock edge.
  - The acceptance decision in that same cycle uses the old mask.
- Eligibility and priority:
  - eligible = pending & mask.
  - Lowest index has highest priority.
- State machine (registered, one transition per clk):
  - IDLE:
    - If eligible != 0: irq_id <= highest-priority eligible index; vec_addr <= VEC_BASE + irq_id*VEC_STRIDE (truncated to VEC_WIDTH); clear that pending bit; go to REQUEST.
    - Otherwise stay in IDLE.
  - REQUEST:
    - s_interrup = 1 for exactly this one cycle; in_service = 1.
    - Always go to SERVICE next.
    - fin_interrup is ignored in this state.
  - SERVICE:
    - s_interrup = 0; in_service = 1.
    - New edges accumulate in pending; no nesting, no preemption.
    - On fin_interrup = 1, go to IDLE; in_service drops on the next cycle.
  - fin_interrup in IDLE is ignored.
- Outputs:
  - s_interrup and in_service are decoded from the state register only (glitch-free, registered).
  - vec_addr and irq_id hold their values from acceptance until the next acceptance.
- Back-to-back requests:
  - After fin_interrup, the earliest next s_interrup is 2 cycles later (IDLE cycle, then REQUEST).
  - This guarantees the control unit completes its pop before the next push.
- Masking a line while it is in service does not abort the service.
- A reset asserted mid-service returns to IDLE immediately, with all pending bits lost.

Test Plan:
- Reset, then mask_we with mask_d=4'b0001, then pulse irq_in[0] -> pending[0]=1 three edges after the rise; next cycle s_interrup=1 for exactly 1 cycle, vec_addr=10'h3C0, irq_id=0, pending[0] cleared, in_service=1.
- mask=4'b1111, raise irq_in[2] and irq_in[1] in the same cycle -> line 1 accepted first (vec_addr=10'h3D0); fin_interrup pulse -> 2 cycles later s_interrup with irq_id=2, vec_addr=10'h3E0.
- During SERVICE of line 0, raise irq_in[3] -> no s_interrup and pending[3]=1 until fin_interrup; then line 3 served with vec_addr=10'h3F0.
- mask=0, raise irq_in[1] -> pending[1]=1 and s_interrup stays 0 for 20 cycles; then write mask=4'b0010 -> request issued on the cycle after the write, not the write cycle.
- Pulse fin_interrup while in IDLE -> no state change, all outputs unchanged; pull reset low during SERVICE -> in_service, pending and mask are 0 immediately (asynchronously).

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller in front of the monocycle control unit: synchronises and
// edge-detects external lines, latches them pending, masks, prioritises and hands out one vector.
module irq_ctrl #(
    parameter int          NUM_IRQ    = 4,
    parameter int          VEC_WIDTH  = 10,
    parameter int unsigned VEC_BASE   = 32'h3C0,
    parameter int unsigned VEC_STRIDE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic                 mask_we,
    input  logic [NUM_IRQ-1:0]   mask_d,
    input  logic                 fin_interrup,
    output logic                 s_interrup,
    output logic [VEC_WIDTH-1:0] vec_addr,
    output logic                 in_service,
    output logic [2:0]           irq_id,
    output logic [NUM_IRQ-1:0]   pending,
    output logic [NUM_IRQ-1:0]   mask
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   sync1_q, sync2_q, prev_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d_int;
    logic [2:0]           irq_id_q, irq_id_d;
    logic [VEC_WIDTH-1:0] vec_addr_q, vec_addr_d;

    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   clr;
    logic [2:0]           sel;

    function automatic logic [VEC_WIDTH-1:0] vec_of(input logic [2:0] id);
        int unsigned a;
        a = VEC_BASE + 32'(id) * VEC_STRIDE;
        return a[VEC_WIDTH-1:0];
    endfunction

    assign rise     = sync2_q & ~prev_q;
    assign eligible = pending_q & mask_q;

    // Descending scan so the lowest eligible index is the one left in sel.
    always_comb begin
        sel = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = 3'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        vec_addr_d = vec_addr_q;
        clr        = '0;
        mask_d_int = mask_we ? mask_d : mask_q;
        case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    irq_id_d   = sel;
                    vec_addr_d = vec_of(sel);
                    clr[sel]   = 1'b1;
                    state_d    = REQUEST;
                end
            end
            REQUEST: state_d = SERVICE;
            SERVICE: if (fin_interrup) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Set after clear so an edge arriving on the accept cycle survives.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            irq_id_q   <= '0;
            vec_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= irq_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            pending_q  <= pending_d;
            mask_q     <= mask_d_int;
            irq_id_q   <= irq_id_d;
            vec_addr_q <= vec_addr_d;
        end
    end

    assign s_interrup = (state_q == REQUEST);
    assign in_service = (state_q != IDLE);
    assign vec_addr   = vec_addr_q;
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule
